// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite bus bundle: five channels, 32-bit address and data.
// The slave modport is used by the register block; the master modport by whoever drives it.
interface axi_lite_slave_if;
    // Write address channel
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    // Write data channel
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    // Write response channel
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    // Read address channel
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    // Read data channel
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    modport slave (
        input  AWVALID, AWADDR, AWPROT,
        input  WVALID, WDATA, WSTRB,
        input  BREADY,
        input  ARVALID, ARADDR, ARPROT,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BRESP,
        output ARREADY, RVALID, RDATA, RRESP
    );

    modport master (
        output AWVALID, AWADDR, AWPROT,
        output WVALID, WDATA, WSTRB,
        output BREADY,
        output ARVALID, ARADDR, ARPROT,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BRESP,
        input  ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_slave.sv
// AXI4-Lite register file: NUM_REGS x 32-bit registers (power of two, 2..64).
// Independent write and read state machines; every bus output comes straight from a flop.
// Out-of-range accesses (byte address >= 4*NUM_REGS) answer SLVERR and touch nothing.
module axi_lite_slave #(
    parameter int NUM_REGS = 8
) (
    input  logic          ACLK,
    input  logic          ARESET,
    axi_lite_slave_if.slave s_axi
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Register storage
    logic [31:0] regs_reg [NUM_REGS];

    // Write side state
    w_state_t    w_state_reg;
    logic        aw_held_reg;
    logic        w_held_reg;
    logic [31:0] awaddr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        awready_reg;
    logic        wready_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;

    // Read side state
    r_state_t    r_state_reg;
    logic        arready_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;

    // Handshakes only count against our registered ready, so nothing is taken while a response is pending.
    logic aw_fire;
    logic w_fire;
    logic ar_fire;
    assign aw_fire = s_axi.AWVALID && awready_reg;
    assign w_fire  = s_axi.WVALID  && wready_reg;
    assign ar_fire = s_axi.ARVALID && arready_reg;

    // Commit uses whatever is already held, or what is arriving at this very edge.
    logic [31:0] cmt_addr;
    logic [31:0] cmt_data;
    logic [3:0]  cmt_strb;
    logic        commit;
    logic        cmt_in_range;
    logic [IDX_W-1:0] cmt_idx;

    assign cmt_addr     = aw_held_reg ? awaddr_reg : s_axi.AWADDR;
    assign cmt_data     = w_held_reg  ? wdata_reg  : s_axi.WDATA;
    assign cmt_strb     = w_held_reg  ? wstrb_reg  : s_axi.WSTRB;
    assign commit       = (w_state_reg == W_IDLE) && (aw_held_reg || aw_fire) && (w_held_reg || w_fire);
    assign cmt_in_range = (cmt_addr[31:IDX_W+2] == '0);
    assign cmt_idx      = cmt_addr[IDX_W+1:2];

    // Byte-lane mask expanded from the strobes
    logic [31:0] wr_mask;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_mask[8*gi +: 8] = {8{cmt_strb[gi]}};
    end

    // One write enable per register
    logic [NUM_REGS-1:0] reg_we;
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
        assign reg_we[gi] = commit && cmt_in_range && (cmt_idx == IDX_W'(gi));
    end

    // Read address decode
    logic             ar_in_range;
    logic [IDX_W-1:0] ar_idx;
    assign ar_in_range = (s_axi.ARADDR[31:IDX_W+2] == '0);
    assign ar_idx      = s_axi.ARADDR[IDX_W+1:2];

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.AWPROT, s_axi.ARPROT, cmt_addr[1:0], s_axi.ARADDR[1:0]};

    // Register array: clear on reset, masked byte update on an in-range commit
    always_ff @(posedge ACLK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ARESET) begin
                regs_reg[i] <= '0;
            end else if (reg_we[i]) begin
                regs_reg[i] <= (regs_reg[i] & ~wr_mask) | (cmt_data & wr_mask);
            end
        end
    end

    // Write FSM: collect AW and W in any order, commit once both are present, then hold the response
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (commit) begin
                        w_state_reg <= W_RESP;
                        bvalid_reg  <= 1'b1;
                        bresp_reg   <= cmt_in_range ? RESP_OKAY : RESP_SLVERR;
                        awready_reg <= 1'b0;
                        wready_reg  <= 1'b0;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                    end else begin
                        if (aw_fire) begin
                            aw_held_reg <= 1'b1;
                            awaddr_reg  <= s_axi.AWADDR;
                            awready_reg <= 1'b0;
                        end else begin
                            awready_reg <= !aw_held_reg;
                        end
                        if (w_fire) begin
                            w_held_reg <= 1'b1;
                            wdata_reg  <= s_axi.WDATA;
                            wstrb_reg  <= s_axi.WSTRB;
                            wready_reg <= 1'b0;
                        end else begin
                            wready_reg <= !w_held_reg;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        w_state_reg <= W_IDLE;
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        wready_reg  <= 1'b1;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    // Read FSM: capture the address, present registered data one cycle later, hold until taken
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_reg <= R_IDLE;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        r_state_reg <= R_DATA;
                        arready_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        rdata_reg   <= ar_in_range ? regs_reg[ar_idx] : '0;
                        rresp_reg   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.RREADY) begin
                        r_state_reg <= R_IDLE;
                        rvalid_reg  <= 1'b0;
                        arready_reg <= 1'b1;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    assign s_axi.AWREADY = awready_reg;
    assign s_axi.WREADY  = wready_reg;
    assign s_axi.BVALID  = bvalid_reg;
    assign s_axi.BRESP   = bresp_reg;
    assign s_axi.ARREADY = arready_reg;
    assign s_axi.RVALID  = rvalid_reg;
    assign s_axi.RDATA   = rdata_reg;
    assign s_axi.RRESP   = rresp_reg;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Scoreboard bench for axi_lite_slave: a reference register model predicts every B and R beat,
// expectations are queued at issue time and checked when the DUT hands the beat over.
module tb_axi_lite_slave;

    localparam int N = 8;

    logic ACLK = 1'b0;
    logic ARESET;

    always #5 ACLK = ~ACLK;

    axi_lite_slave_if bus();

    axi_lite_slave #(.NUM_REGS(N)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [N];
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];   // {rresp, rdata}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
        int idx;
        if (addr >= 32'(4 * N)) return 2'b10;
        idx = int'(addr >> 2);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [33:0] mdl_read(input logic [31:0] addr);
        if (addr >= 32'(4 * N)) return {2'b10, 32'h0};
        return {2'b00, mdl[int'(addr >> 2)]};
    endfunction

    // Monitor: pop and compare each completed response beat
    always begin
        @(negedge ACLK);
        #1;
        if (!ARESET) begin
            if (bus.BVALID && bus.BREADY) begin
                chk("b_expected", 32'(exp_b_q.size() > 0), 32'd1);
                if (exp_b_q.size() > 0) chk("bresp", 32'(bus.BRESP), 32'(exp_b_q.pop_front()));
                $display("B beat bresp=%0d", bus.BRESP);
            end
            if (bus.RVALID && bus.RREADY) begin
                logic [33:0] e;
                chk("r_expected", 32'(exp_r_q.size() > 0), 32'd1);
                if (exp_r_q.size() > 0) begin
                    e = exp_r_q.pop_front();
                    chk("rdata", bus.RDATA, e[31:0]);
                    chk("rresp", 32'(bus.RRESP), 32'(e[33:32]));
                end
                $display("R beat rdata=0x%08h rresp=%0d", bus.RDATA, bus.RRESP);
            end
        end
    end

    task automatic wait_w_idle();
        int n = 0;
        while (!(bus.AWREADY && bus.WREADY) && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("aw_w_ready_wait", 32'(bus.AWREADY && bus.WREADY), 32'd1);
    endtask

    task automatic wait_r_idle();
        int n = 0;
        while (!bus.ARREADY && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("ar_ready_wait", 32'(bus.ARREADY), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b_q.size() + exp_r_q.size()) != 0 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("drain_left", 32'(exp_b_q.size() + exp_r_q.size()), 32'd0);
    endtask

    // Write with W leading AW by 'lead' cycles (0 = same cycle)
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead);
        wait_w_idle();
        exp_b_q.push_back(mdl_write(addr, data, strb));
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WVALID = 1'b1;
        if (lead > 0) begin
            @(negedge ACLK);
            bus.WVALID = 1'b0;
            bus.WDATA  = $urandom;
            bus.WSTRB  = 4'($urandom);
            for (int i = 0; i < lead; i++) begin
                if (i > 0) @(negedge ACLK);
                chk("wready_while_held", 32'(bus.WREADY), 32'd0);
                chk("awready_while_held", 32'(bus.AWREADY), 32'd1);
            end
        end
        bus.AWADDR  = addr;
        bus.AWPROT  = 3'($urandom);
        bus.AWVALID = 1'b1;
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        chk("bvalid_latency", 32'(bus.BVALID), 32'd1);
        chk("awready_in_resp", 32'(bus.AWREADY), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr);
        wait_r_idle();
        exp_r_q.push_back(mdl_read(addr));
        bus.ARADDR  = addr;
        bus.ARPROT  = 3'($urandom);
        bus.ARVALID = 1'b1;
        @(negedge ACLK);
        bus.ARVALID = 1'b0;
        chk("rvalid_latency", 32'(bus.RVALID), 32'd1);
    endtask

    // Write commit and read capture on the same edge
    task automatic axi_write_read(input logic [31:0] waddr, input logic [31:0] data,
                                  input logic [31:0] raddr);
        wait_w_idle();
        wait_r_idle();
        exp_r_q.push_back(mdl_read(raddr));
        exp_b_q.push_back(mdl_write(waddr, data, 4'hF));
        bus.AWADDR = waddr;  bus.AWVALID = 1'b1;
        bus.WDATA  = data;   bus.WSTRB   = 4'hF;  bus.WVALID = 1'b1;
        bus.ARADDR = raddr;  bus.ARVALID = 1'b1;
        @(negedge ACLK);
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        bus.ARVALID = 1'b0;
        chk("bvalid_latency_c", 32'(bus.BVALID), 32'd1);
        chk("rvalid_latency_c", 32'(bus.RVALID), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  eb;
        logic [33:0] er;
        ARESET      = 1'b1;
        bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWPROT = '0;
        bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB  = '0;
        bus.BREADY  = 1'b1;
        bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = '0;
        bus.RREADY  = 1'b1;
        for (int i = 0; i < N; i++) mdl[i] = '0;

        // Reset values
        repeat (3) @(negedge ACLK);
        chk("rst_awready", 32'(bus.AWREADY), 32'd0);
        chk("rst_wready",  32'(bus.WREADY),  32'd0);
        chk("rst_arready", 32'(bus.ARREADY), 32'd0);
        chk("rst_bvalid",  32'(bus.BVALID),  32'd0);
        chk("rst_rvalid",  32'(bus.RVALID),  32'd0);
        chk("rst_bresp",   32'(bus.BRESP),   32'd0);
        chk("rst_rresp",   32'(bus.RRESP),   32'd0);
        chk("rst_rdata",   bus.RDATA,        32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("post_rst_awready", 32'(bus.AWREADY), 32'd1);
        chk("post_rst_wready",  32'(bus.WREADY),  32'd1);
        chk("post_rst_arready", 32'(bus.ARREADY), 32'd1);

        // AW and W together, then read back
        axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0);
        axi_read(32'h4);
        drain();

        // W three cycles ahead of AW, partial strobes into reg 2
        axi_write(32'h8, 32'h11223344, 4'b0101, 3);
        axi_read(32'h8);
        drain();

        // Out of range write and read, then confirm nothing moved
        axi_write(32'h20, 32'hCAFEF00D, 4'hF, 0);
        axi_read(32'h40);
        drain();
        for (int i = 0; i < N; i++) axi_read(32'(4 * i));
        drain();

        // Reg 1 = 5, then an all-zero strobe write must leave it alone
        axi_write(32'h4 | 32'h1, 32'h5, 4'hF, 1);
        axi_write(32'h4, 32'hFFFFFFFF, 4'h0, 0);
        axi_read(32'h4);
        drain();

        // Same-edge write and read to reg 1: read sees the old value, a later read the new one
        axi_write_read(32'h4, 32'h9, 32'h4);
        drain();
        axi_read(32'h4);
        drain();

        // Back-pressure on both response channels for five cycles
        bus.BREADY = 1'b0;
        bus.RREADY = 1'b0;
        axi_write_read(32'hC, 32'hA5A50001, 32'h8);
        eb = exp_b_q[0];
        er = exp_r_q[0];
        for (int i = 0; i < 5; i++) begin
            chk("stall_bvalid",  32'(bus.BVALID),  32'd1);
            chk("stall_rvalid",  32'(bus.RVALID),  32'd1);
            chk("stall_bresp",   32'(bus.BRESP),   32'(eb));
            chk("stall_rresp",   32'(bus.RRESP),   32'(er[33:32]));
            chk("stall_rdata",   bus.RDATA,        er[31:0]);
            chk("stall_awready", 32'(bus.AWREADY), 32'd0);
            chk("stall_wready",  32'(bus.WREADY),  32'd0);
            chk("stall_arready", 32'(bus.ARREADY), 32'd0);
            @(negedge ACLK);
        end
        bus.BREADY = 1'b1;
        bus.RREADY = 1'b1;
        drain();
        chk("release_awready", 32'(bus.AWREADY), 32'd1);
        chk("release_wready",  32'(bus.WREADY),  32'd1);
        chk("release_arready", 32'(bus.ARREADY), 32'd1);
        chk("release_bvalid",  32'(bus.BVALID),  32'd0);

        // Random mix, including out-of-range addresses and sub-word address bits
        for (int t = 0; t < 30; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2));
            else
                axi_read(a);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // Reset while a write response is pending
        bus.BREADY = 1'b0;
        axi_write(32'h14, 32'h77777777, 4'hF, 0);
        chk("pending_bvalid", 32'(bus.BVALID), 32'd1);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("rst_mid_bvalid",  32'(bus.BVALID),  32'd0);
        chk("rst_mid_awready", 32'(bus.AWREADY), 32'd0);
        ARESET = 1'b0;
        bus.BREADY = 1'b1;
        exp_b_q.delete();
        exp_r_q.delete();
        for (int i = 0; i < N; i++) mdl[i] = '0;
        @(negedge ACLK);
        chk("rst_mid_ready_back", 32'(bus.AWREADY && bus.WREADY && bus.ARREADY), 32'd1);
        for (int i = 0; i < N; i++) axi_read(32'(4 * i));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
